// File: rtl/snn_load_ctrl.sv
// snn_load_ctrl: sequencer between the UART receiver, the 1-bit input-image
// RAM, snn_core and the UART transmitter.
//
// Received bytes are unpacked LSB-first into NUM_PIXELS single-bit RAM writes
// (bit 0 of byte k lands at address 8k). Once the last pixel is written, the
// core is started. Its result is latched and handed to the transmitter as
// {4'h0, digit}.
//
// Optional build macro: SNN_LOAD_CTRL_RX_TIMEOUT_EN
//   If defined, a partial image is discarded after TIMEOUT_CYC idle cycles in
//   WAIT_BYTE, so that framing recovers after a lost byte. If undefined,
//   WAIT_BYTE waits indefinitely and no timeout counter exists.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for the first byte of an image (pointer = 0)
// WAIT_BYTE | waiting for the next byte of a partially loaded image
// UNPACK    | 8 cycles, one RAM write per bit of the captured byte
// START     | one-cycle core start pulse; core owns the RAM address
// RUN       | waiting for core_done
// SEND      | waiting for tx_rdy to hand the digit to the transmitter
module snn_load_ctrl #(
  parameter int NUM_PIXELS  = 784,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              load_sel,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  input  logic              tx_rdy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [3:0]        digit,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BYTE, S_UNPACK, S_START, S_RUN, S_SEND
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_PIXELS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [3:0]          digit_q, digit_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                overrun_q, overrun_d;
  logic                ram_we_q, ram_we_d;
  logic                core_start_q, core_start_d;
  logic                tx_start_q, tx_start_d;
  logic                load_sel_q, load_sel_d;
  logic                busy_q, busy_d;
`ifdef SNN_LOAD_CTRL_RX_TIMEOUT_EN
  logic [31:0]         tmo_q, tmo_d;
`endif

  // Next-state and next-output computation; outputs are registered from state_d
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    digit_d    = digit_q;
    tx_data_d  = tx_data_q;
    overrun_d  = overrun_q;
    tx_start_d = 1'b0;
`ifdef SNN_LOAD_CTRL_RX_TIMEOUT_EN
    tmo_d      = '0;
`endif
    case (state_q)
      S_IDLE, S_WAIT_BYTE: begin
        if (rx_rdy) begin
          shift_d   = rx_data;
          bit_cnt_d = '0;
          state_d   = S_UNPACK;
        end
`ifdef SNN_LOAD_CTRL_RX_TIMEOUT_EN
        else if (state_q == S_WAIT_BYTE) begin
          if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
            ptr_d   = '0;
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
`endif
      end
      S_UNPACK: begin
        if (rx_rdy) overrun_d = 1'b1;
        shift_d   = {1'b0, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7 && ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = S_START;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
          if (bit_cnt_q == 3'd7) state_d = S_WAIT_BYTE;
        end
      end
      S_START: begin
        if (rx_rdy) overrun_d = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (rx_rdy) overrun_d = 1'b1;
        if (core_done) begin
          digit_d = core_digit;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (rx_rdy) overrun_d = 1'b1;
        if (tx_rdy) begin
          tx_start_d = 1'b1;
          tx_data_d  = {4'h0, digit_q};
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ram_we_d     = (state_d == S_UNPACK);
    core_start_d = (state_d == S_START);
    load_sel_d   = !(state_d == S_START || state_d == S_RUN);
    busy_d       = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      digit_q      <= '0;
      tx_data_q    <= '0;
      overrun_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      core_start_q <= 1'b0;
      tx_start_q   <= 1'b0;
      load_sel_q   <= 1'b1;
      busy_q       <= 1'b0;
`ifdef SNN_LOAD_CTRL_RX_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      digit_q      <= digit_d;
      tx_data_q    <= tx_data_d;
      overrun_q    <= overrun_d;
      ram_we_q     <= ram_we_d;
      core_start_q <= core_start_d;
      tx_start_q   <= tx_start_d;
      load_sel_q   <= load_sel_d;
      busy_q       <= busy_d;
`ifdef SNN_LOAD_CTRL_RX_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  // Address and data come straight from the pointer and shift register flops
  assign ram_addr   = ptr_q;
  assign ram_wdata  = shift_q[0];
  assign ram_we     = ram_we_q;
  assign load_sel   = load_sel_q;
  assign core_start = core_start_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign digit      = digit_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_snn_load_ctrl.sv
// Self-checking bench for snn_load_ctrl: table-driven inference records,
// randomized images and gaps checked against a pixel-level image model,
// plus hand-written overrun, mid-load reset and rx-timeout sequences.
module tb_snn_load_ctrl;
  localparam int NP = 784;
  localparam int AW = 10;
`ifdef SNN_LOAD_CTRL_RX_TIMEOUT_EN
  localparam int TMO = 1000;
`else
  localparam int TMO = 5000000;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          core_done = 1'b0;
  logic [3:0]    core_digit = 4'h0;
  logic          tx_rdy = 1'b0;
  logic          ram_we, ram_wdata, load_sel, core_start, tx_start, busy, overrun;
  logic [AW-1:0] ram_addr;
  logic [7:0]    tx_data;
  logic [3:0]    digit;

  snn_load_ctrl #(.NUM_PIXELS(NP), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .load_sel(load_sel), .core_start(core_start), .core_done(core_done),
    .core_digit(core_digit), .tx_rdy(tx_rdy), .tx_start(tx_start),
    .tx_data(tx_data), .digit(digit), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observed write stream and pulse events, sampled just after each rising edge
  int          tb_ram[NP];
  int          wq[$];
  int          wr_cnt = 0, start_cnt = 0, start_cyc = 0, tx_cnt = 0, tx_cyc = 0, bad_addr = 0;
  logic        ls_at_start = 1'b1, busy_at_tx = 1'b1;
  logic [7:0]  txd_at_tx = 8'h00;

  always @(posedge clk) begin
    #1;
    if (ram_we) begin
      if (int'(ram_addr) < NP) tb_ram[ram_addr] = int'(ram_wdata);
      else bad_addr++;
      wq.push_back(int'(ram_addr));
      wr_cnt++;
    end
    if (core_start) begin
      start_cnt++;
      start_cyc   = cyc;
      ls_at_start = load_sel;
    end
    if (tx_start) begin
      tx_cnt++;
      tx_cyc     = cyc;
      busy_at_tx = busy;
      txd_at_tx  = tx_data;
    end
  end

  logic [7:0] img[98];
  int last_rx = 0;
  int inject_at = -1;
  bit rx_with_done = 0;

  task automatic fill_img(input bit rnd, input logic [7:0] val);
    for (int k = 0; k < 98; k++) img[k] = rnd ? 8'($urandom) : val;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < NP; i++) tb_ram[i] = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    last_rx = cyc;
    @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  task automatic send_bytes(input int s, input int e, input int lo, input int hi);
    int keep;
    for (int k = s; k <= e; k++) begin
      send_byte(img[k]);
      if (k == inject_at) begin
        keep = last_rx;
        @(negedge clk);
        send_byte(8'hFF);
        last_rx = keep;
      end
      repeat ($urandom_range(lo, hi)) @(negedge clk);
    end
  endtask

  // Loads img[s..97]; expected RAM contents are the image bits, LSB first
  task automatic load_image(input int s, input int lo, input int hi);
    int w0, sc0, mism, exp_bit;
    if (s == 0) clear_ram();
    w0  = wr_cnt;
    sc0 = start_cnt;
    send_bytes(s, 97, lo, hi);
    repeat (4) @(negedge clk);
    mism = 0;
    for (int i = 0; i < NP; i++) begin
      exp_bit = (int'(img[i / 8]) >> (i % 8)) & 1;
      if (tb_ram[i] != exp_bit) mism++;
    end
    chk("wr_count", wr_cnt - w0, 8 * (98 - s));
    chk("ram_image_mismatches", mism, 0);
    chk("first_addr", (wq.size() > w0) ? wq[w0] : -1, 8 * s);
    chk("last_addr", (wq.size() > 0) ? wq[wq.size() - 1] : -1, NP - 1);
    chk("start_pulses", start_cnt - sc0, 1);
    chk("start_latency", start_cyc - last_rx, 9);
    chk("load_sel_at_start", ls_at_start, 0);
    chk("addr_in_range", bad_addr, 0);
  endtask

  task automatic run_inference(input logic [3:0] dig, input int delay, input logic [7:0] exp_tx);
    int txc0, dcyc, exp_cyc;
    chk("run_busy", busy, 1);
    chk("run_load_sel", load_sel, 0);
    repeat (3) @(negedge clk);
    chk("run_load_sel_hold", load_sel, 0);
    tx_rdy = (delay == 0);
    @(negedge clk);
    core_done  = 1'b1;
    core_digit = dig;
    if (rx_with_done) rx_rdy = 1'b1;
    dcyc = cyc;
    txc0 = tx_cnt;
    @(negedge clk);
    core_done = 1'b0;
    rx_rdy    = 1'b0;
    chk("digit_latched", digit, dig);
    chk("send_load_sel", load_sel, 1);
    if (delay > 0) begin
      repeat (delay) @(negedge clk);
      chk("tx_held_while_not_rdy", tx_cnt - txc0, 0);
      chk("send_busy", busy, 1);
      tx_rdy  = 1'b1;
      exp_cyc = cyc + 1;
    end else begin
      exp_cyc = dcyc + 2;
    end
    for (int i = 0; i < 20 && tx_cnt == txc0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("tx_pulses", tx_cnt - txc0, 1);
    chk("tx_latency_cycle", tx_cyc, exp_cyc);
    chk("tx_data_at_pulse", txd_at_tx, exp_tx);
    chk("busy_at_tx", busy_at_tx, 0);
    chk("tx_data_hold", tx_data, exp_tx);
    chk("digit_hold", digit, dig);
    chk("idle_busy", busy, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_digit"}, digit, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_load_sel"}, load_sel, 1);
  endtask

  typedef struct {
    bit         rnd;
    logic [7:0] fill;
    int         gap_lo;
    int         gap_hi;
    logic [3:0] dig;
    int         delay;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{0, 8'hA5, 99, 99, 4'd7, 0, 8'h07};
    tbl[1] = '{0, 8'hA5, 9, 15, 4'd7, 50, 8'h07};
    tbl[2] = '{1, 8'h00, 9, 30, 4'd0, 5, 8'h00};
    tbl[3] = '{0, 8'h3C, 9, 9, 4'd15, 0, 8'h0F};

    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      fill_img(tbl[v].rnd, tbl[v].fill);
      load_image(0, tbl[v].gap_lo, tbl[v].gap_hi);
      run_inference(tbl[v].dig, tbl[v].delay, tbl[v].exp_tx);
    end

    // Overrun: byte during UNPACK, byte alone in RUN, byte together with core_done
    fill_img(1, 8'h00);
    chk("overrun_before", overrun, 0);
    inject_at = 20;
    load_image(0, 9, 20);
    inject_at = -1;
    chk("overrun_unpack", overrun, 1);
    begin
      int w;
      w = wr_cnt;
      send_byte(8'h55);
      repeat (2) @(negedge clk);
      chk("run_drop_writes", wr_cnt - w, 0);
      chk("overrun_run", overrun, 1);
      chk("run_drop_busy", busy, 1);
    end
    rx_with_done = 1;
    run_inference(4'd9, 3, 8'h09);
    rx_with_done = 0;
    begin
      int t0;
      t0 = tx_cnt;
      @(negedge clk);
      core_done  = 1'b1;
      core_digit = 4'd3;
      @(negedge clk);
      core_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("done_outside_run_digit", digit, 9);
      chk("done_outside_run_tx", tx_cnt - t0, 0);
      chk("done_outside_run_busy", busy, 0);
      chk("overrun_sticky", overrun, 1);
    end

    // Reset in the middle of unpacking the 40th byte
    fill_img(1, 8'h00);
    clear_ram();
    send_bytes(0, 38, 9, 15);
    send_byte(img[39]);
    repeat (2) @(negedge clk);
    begin
      int t0;
      t0 = tx_cnt;
      rst_n = 1'b0;
      #1;
      chk_reset("midload");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_no_tx", tx_cnt - t0, 0);
    end
    fill_img(1, 8'h00);
    load_image(0, 9, 20);
    run_inference(4'd5, 0, 8'h05);

    // Ten bytes, then a long idle gap in WAIT_BYTE
    fill_img(1, 8'h00);
    clear_ram();
    send_bytes(0, 9, 9, 12);
    repeat (1005) @(negedge clk);
`ifdef SNN_LOAD_CTRL_RX_TIMEOUT_EN
    chk("timeout_to_idle", busy, 0);
    chk("timeout_overrun_unaffected", overrun, 0);
    load_image(0, 9, 20);
`else
    chk("no_timeout_still_busy", busy, 1);
    load_image(10, 9, 20);
`endif
    run_inference(4'd2, 1, 8'h02);

    // Randomized images, gaps, digits and transmitter delays
    for (int r = 0; r < 3; r++) begin
      logic [3:0] d;
      int dl;
      d  = 4'($urandom_range(0, 15));
      dl = $urandom_range(0, 20);
      fill_img(1, 8'h00);
      load_image(0, 9, 25);
      run_inference(d, dl, {4'h0, d});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
